// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline plus the MULT/DIV busy sequencer.
// Interlocks on RAW hazards against EXE/MEM destinations (no forwarding) and on HI/LO structural hazards.
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES   = 4,
   parameter int DIV_CYCLES   = 32,
   parameter bit BRANCH_FLUSH = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        exe_rf_w_ena,
   input  logic        mem_rf_w_ena,
   input  logic [4:0]  exe_rf_waddr,
   input  logic [4:0]  mem_rf_waddr,
   input  logic        id_branch,
   input  logic        id_md_op,
   input  logic        id_md_is_div,
   input  logic        id_hilo_read,
   output logic        pc_ena,
   output logic        if_id_ena,
   output logic        if_id_flush,
   output logic        id_exe_bubble,
   output logic        md_start,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cycles
);

   localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
   localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t  state, state_nxt;
   logic [5:0] cnt, cnt_nxt;
   logic       raw_rs, raw_rt, raw, struct_haz, stall, issue;

   // A source only conflicts with a producer that actually writes a non-zero register.
   assign raw_rs = id_uses_rs && (id_rs != 5'd0) &&
                   ((exe_rf_w_ena && (exe_rf_waddr == id_rs)) ||
                    (mem_rf_w_ena && (mem_rf_waddr == id_rs)));
   assign raw_rt = id_uses_rt && (id_rt != 5'd0) &&
                   ((exe_rf_w_ena && (exe_rf_waddr == id_rt)) ||
                    (mem_rf_w_ena && (mem_rf_waddr == id_rt)));

   assign raw        = id_valid && (raw_rs || raw_rt);
   assign md_busy    = (state == BUSY);
   assign struct_haz = id_valid && md_busy && (id_md_op || id_hilo_read);
   assign stall      = raw || struct_haz;
   assign issue      = !rst && (state == IDLE) && id_valid && id_md_op && !stall;

   // ID hands its instruction on (valid && !stall) in exactly the cycles where pc_ena is high;
   // a stalled instruction stays in ID while a bubble goes downstream.
   always_comb begin
      pc_ena        = 1'b0;
      if_id_ena     = 1'b0;
      if_id_flush   = 1'b0;
      id_exe_bubble = 1'b1;
      md_start      = 1'b0;
      md_done       = 1'b0;
      if (!rst) begin
         pc_ena        = !stall;
         if_id_ena     = !stall;
         id_exe_bubble = stall;
         if_id_flush   = BRANCH_FLUSH && id_branch && id_valid && !stall;
         md_start      = issue;
         md_done       = md_busy && (cnt == 6'd1);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nxt = BUSY;
               cnt_nxt   = id_md_is_div ? DIV_N : MUL_N;
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 6'd1;
            if (cnt == 6'd1) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 6'd0;
         stall_cycles <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (stall) stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two parameterisations share one input stream,
// each checked against a cycle-timeline reference model.
module tb_pipe_hazard_ctrl;
  localparam int W = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_uses_rs, id_uses_rt, exe_rf_w_ena, mem_rf_w_ena;
  logic [4:0] id_rs, id_rt, exe_rf_waddr, mem_rf_waddr;
  logic       id_branch, id_md_op, id_md_is_div, id_hilo_read;

  logic [1:0]  pc_ena, if_id_ena, if_id_flush, id_exe_bubble, md_start, md_busy, md_done;
  logic [31:0] stall_cycles [2];

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .BRANCH_FLUSH(1'b1)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .exe_rf_w_ena(exe_rf_w_ena), .mem_rf_w_ena(mem_rf_w_ena),
    .exe_rf_waddr(exe_rf_waddr), .mem_rf_waddr(mem_rf_waddr),
    .id_branch(id_branch), .id_md_op(id_md_op), .id_md_is_div(id_md_is_div),
    .id_hilo_read(id_hilo_read),
    .pc_ena(pc_ena[0]), .if_id_ena(if_id_ena[0]), .if_id_flush(if_id_flush[0]),
    .id_exe_bubble(id_exe_bubble[0]), .md_start(md_start[0]), .md_busy(md_busy[0]),
    .md_done(md_done[0]), .stall_cycles(stall_cycles[0])
  );

  pipe_hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(63), .BRANCH_FLUSH(1'b0)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .exe_rf_w_ena(exe_rf_w_ena), .mem_rf_w_ena(mem_rf_w_ena),
    .exe_rf_waddr(exe_rf_waddr), .mem_rf_waddr(mem_rf_waddr),
    .id_branch(id_branch), .id_md_op(id_md_op), .id_md_is_div(id_md_is_div),
    .id_hilo_read(id_hilo_read),
    .pc_ena(pc_ena[1]), .if_id_ena(if_id_ena[1]), .if_id_flush(if_id_flush[1]),
    .id_exe_bubble(id_exe_bubble[1]), .md_start(md_start[1]), .md_busy(md_busy[1]),
    .md_done(md_done[1]), .stall_cycles(stall_cycles[1])
  );

  // Reference model: an md op issued in cycle c keeps the unit busy in cycles c+1 .. c+N.
  int          cyc;
  int          md_end [2];
  logic [31:0] scnt [2];
  int          checks = 0;
  int          fails  = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  function automatic int mul_n(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int div_n(int i); return (i == 0) ? 32 : 63; endfunction
  function automatic logic flush_en(int i); return (i == 0); endfunction

  function automatic logic hit(logic u, logic [4:0] r);
    return u && (r != 5'd0) &&
           ((exe_rf_w_ena && exe_rf_waddr == r) || (mem_rf_w_ena && mem_rf_waddr == r));
  endfunction

  task automatic nop_in();
    rst = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; exe_rf_w_ena = 1'b0; mem_rf_w_ena = 1'b0;
    exe_rf_waddr = 5'd0; mem_rf_waddr = 5'd0; id_branch = 1'b0;
    id_md_op = 1'b0; id_md_is_div = 1'b0; id_hilo_read = 1'b0;
  endtask

  // Predict this cycle's outputs from the currently driven inputs, then advance one clock.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      logic busy, raw, strct, stall, pc, bub, fl, start, done;
      logic [W-1:0] e;
      busy  = (cyc <= md_end[i]);
      raw   = id_valid && (hit(id_uses_rs, id_rs) || hit(id_uses_rt, id_rt));
      strct = id_valid && busy && (id_md_op || id_hilo_read);
      stall = raw || strct;
      if (rst) begin
        pc = 1'b0; bub = 1'b1; fl = 1'b0; start = 1'b0; done = 1'b0;
      end else begin
        pc    = !stall;
        bub   = stall;
        fl    = flush_en(i) && id_branch && id_valid && !stall;
        start = !busy && id_valid && id_md_op && !stall;
        done  = busy && (cyc == md_end[i]);
      end
      e = {pc, pc, fl, bub, start, busy, done, scnt[i]};
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      if (rst) begin
        md_end[i] = -1;
        scnt[i]   = 32'd0;
      end else begin
        if (stall) scnt[i] = scnt[i] + 32'd1;
        if (start) md_end[i] = cyc + (id_md_is_div ? div_n(i) : mul_n(i));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      nop_in();
      step();
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {pc_ena[0], if_id_ena[0], if_id_flush[0], id_exe_bubble[0],
           md_start[0], md_busy[0], md_done[0], stall_cycles[0]};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL dut0_outputs cycle=%0d actual=%h expected=%h", cyc - 1, a, e);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {pc_ena[1], if_id_ena[1], if_id_flush[1], id_exe_bubble[1],
           md_start[1], md_busy[1], md_done[1], stall_cycles[1]};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL dut1_outputs cycle=%0d actual=%h expected=%h", cyc - 1, a, e);
      end
    end
  end

  initial begin
    cyc = 0;
    md_end[0] = -1; md_end[1] = -1;
    scnt[0] = 32'd0; scnt[1] = 32'd0;
    nop_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // reset cycles with a hazard present: outputs must stay forced
    nop_in(); rst = 1'b1; id_valid = 1'b1; id_md_op = 1'b1; step();
    nop_in(); rst = 1'b1; step();

    // load-use: EXE then MEM holds r5
    nop_in(); id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd5;
    exe_rf_w_ena = 1'b1; exe_rf_waddr = 5'd5; step();
    exe_rf_w_ena = 1'b0; mem_rf_w_ena = 1'b1; mem_rf_waddr = 5'd5; step();
    mem_rf_w_ena = 1'b0; step();

    // zero register never stalls; rt path via MEM
    nop_in(); id_valid = 1'b1; id_uses_rs = 1'b1; exe_rf_w_ena = 1'b1; step();
    nop_in(); id_valid = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd9;
    mem_rf_w_ena = 1'b1; mem_rf_waddr = 5'd9; step();

    // DIV, independent ADD overlaps, MFHI waits for the unit
    nop_in(); id_valid = 1'b1; id_md_op = 1'b1; id_md_is_div = 1'b1; step();
    idle(2);
    nop_in(); id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd1; step();
    for (int k = 0; k < 30; k++) begin
      nop_in(); id_valid = 1'b1; id_hilo_read = 1'b1; step();
    end
    idle(40);

    // back-to-back MULT
    nop_in(); id_valid = 1'b1; id_md_op = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      nop_in(); id_valid = 1'b1; id_md_op = 1'b1; step();
    end
    idle(8);

    // taken branch alone, then with raw until raw clears
    nop_in(); id_valid = 1'b1; id_branch = 1'b1; step();
    nop_in(); id_valid = 1'b1; id_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd7;
    exe_rf_w_ena = 1'b1; exe_rf_waddr = 5'd7; step();
    exe_rf_w_ena = 1'b0; mem_rf_w_ena = 1'b1; mem_rf_waddr = 5'd7; step();
    mem_rf_w_ena = 1'b0; step();

    // md op held back by raw
    nop_in(); id_valid = 1'b1; id_md_op = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd3;
    exe_rf_w_ena = 1'b1; exe_rf_waddr = 5'd3; step();
    exe_rf_w_ena = 1'b0; step();
    idle(70);

    // reset in the middle of a DIV
    nop_in(); id_valid = 1'b1; id_md_op = 1'b1; id_md_is_div = 1'b1; step();
    idle(9);
    nop_in(); rst = 1'b1; id_valid = 1'b1; id_branch = 1'b1; step();
    idle(5);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_uses_rs   = $urandom_range(0, 1);
      id_uses_rt   = $urandom_range(0, 1);
      exe_rf_w_ena = ($urandom_range(0, 2) == 0);
      mem_rf_w_ena = ($urandom_range(0, 2) == 0);
      exe_rf_waddr = 5'($urandom_range(0, 7));
      mem_rf_waddr = 5'($urandom_range(0, 7));
      id_branch    = ($urandom_range(0, 3) == 0);
      id_md_op     = ($urandom_range(0, 7) == 0);
      id_md_is_div = $urandom_range(0, 1);
      id_hilo_read = ($urandom_range(0, 7) == 0);
      step();
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0",
               exp_q0.size() + exp_q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
